// File: rtl/dft_test_sequencer.sv
// DFT test sequencer: walks the prewrapper through a functional run or scan test.
// Optional watchdog per wait phase is built when SEQ_TIMEOUT_EN is defined.
module dft_test_sequencer #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cfg_mode,
   input  logic [CNT_W-1:0] cfg_iters,
   input  logic [31:0]      ctrl_state,
   output logic [31:0]      ctrl_opcode,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] scan_idx
);

   localparam logic [31:0] OP_NONE  = 32'd0;
   localparam logic [31:0] OP_INPUT = 32'd1;
   localparam logic [31:0] OP_RUN   = 32'd2;
   localparam logic [31:0] OP_ENDR  = 32'd3;
   localparam logic [31:0] OP_TEST  = 32'd4;
   localparam logic [31:0] OP_NEXT  = 32'd5;
   localparam logic [31:0] OP_ENDT  = 32'd6;

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_INPUT_RDY  = 4'd3;
   localparam logic [3:0] ST_OUTPUT_VAL = 4'd5;
   localparam logic [3:0] ST_SCAN_RD    = 4'd9;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INPUT,
      S_GO,
      S_ENDR,
      S_NEXT,
      S_WAIT_RD,
      S_ENDT,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             mode_q;
   logic             mode_nxt;
   logic [CNT_W-1:0] iters_q;
   logic [CNT_W-1:0] iters_nxt;
   logic [CNT_W-1:0] idx_nxt;
   logic [31:0]      op_nxt;
   logic             busy_nxt;
   logic [3:0]       code;
   logic             more;
   logic             in_wait;
   logic             tmo;

   assign code    = ctrl_state[3:0];
   assign more    = (scan_idx < iters_q);
   assign in_wait = !(state inside {S_IDLE, S_DONE, S_ERR});

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   assign tmo = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: restarts on every state change, counts while waiting
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state_nxt != state) begin
         wd_cnt <= '0;
      end else if (in_wait) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Sticky error: held for as long as the FSM sits in S_ERR
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= (state_nxt == S_ERR);
      end
   end
`else
   logic [31:0] unused_tmo;

   assign unused_tmo = 32'(TIMEOUT_CYCLES);
   assign tmo        = 1'b0;
   assign err        = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{ctrl_state[31:4], in_wait};

   // Next-state, config latch and scan index update
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      iters_nxt = iters_q;
      idx_nxt   = scan_idx;
      case (state)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_nxt = S_INPUT;
               mode_nxt  = cfg_mode;
               iters_nxt = cfg_iters;
               idx_nxt   = '0;
            end
         end
         S_INPUT: begin
            if (code == ST_INPUT_RDY) begin
               state_nxt = S_GO;
            end
         end
         S_GO: begin
            if (!mode_q) begin
               if (code == ST_OUTPUT_VAL) begin
                  state_nxt = S_ENDR;
               end
            end else if (code == ST_SCAN_RD) begin
               state_nxt = more ? S_NEXT : S_ENDT;
            end
         end
         S_ENDR: begin
            if (code == ST_IDLE) begin
               state_nxt = S_DONE;
            end
         end
         S_NEXT: begin
            if (code != ST_SCAN_RD) begin
               idx_nxt   = scan_idx + 1'b1;
               state_nxt = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            if (code == ST_SCAN_RD) begin
               state_nxt = more ? S_NEXT : S_ENDT;
            end
         end
         S_ENDT: begin
            if (code == ST_IDLE) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (tmo && (state_nxt == state)) begin
         state_nxt = S_ERR;
      end
   end

   // Output decode from the upcoming state so outputs register with it
   always_comb begin
      op_nxt   = OP_NONE;
      busy_nxt = !(state_nxt inside {S_IDLE, S_DONE, S_ERR});
      case (state_nxt)
         S_INPUT: op_nxt = OP_INPUT;
         S_GO:    op_nxt = mode_nxt ? OP_TEST : OP_RUN;
         S_ENDR:  op_nxt = OP_ENDR;
         S_NEXT:  op_nxt = OP_NEXT;
         S_ENDT:  op_nxt = OP_ENDT;
         default: op_nxt = OP_NONE;
      endcase
   end

   // State, latched config and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         mode_q      <= 1'b0;
         iters_q     <= '0;
         scan_idx    <= '0;
         ctrl_opcode <= OP_NONE;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode_q      <= mode_nxt;
         iters_q     <= iters_nxt;
         scan_idx    <= idx_nxt;
         ctrl_opcode <= op_nxt;
         busy        <= busy_nxt;
         done        <= (state_nxt == S_DONE);
      end
   end

endmodule
